// File: rtl/mux_serial_deser.sv
// Serial-to-parallel reassembly of the 8-to-1 mux stream, indexed by select tag.
// Completed words are held in one output register behind a valid/ready port.
module mux_serial_deser #(
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(WIDTH),
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic [SEL_W-1:0] sel_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             seq_err,
   output logic             busy,
   output logic [CNT_W-1:0] word_cnt
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

   logic [SEL_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] asm_q, asm_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             ov_q, ov_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             handoff;

   // Only the final bit needs the holding register free.
   assign bit_ready = (idx_q != LAST) || !ov_q || out_ready;
   assign accept    = bit_valid && bit_ready;
   assign handoff   = ov_q && out_ready;

   always_comb begin
      idx_d = idx_q;
      asm_d = asm_q;
      out_d = out_q;
      ov_d  = ov_q && !out_ready;
      err_d = 1'b0;
      cnt_d = cnt_q + CNT_W'(handoff);
      if (flush) begin
         idx_d = '0;
         asm_d = '0;
      end else if (accept) begin
         if (sel_in == idx_q) begin
            if (idx_q == LAST) begin
               out_d = {bit_in, asm_q[WIDTH-2:0]};
               ov_d  = 1'b1;
               idx_d = '0;
               asm_d = '0;
            end else begin
               asm_d[idx_q] = bit_in;
               idx_d        = idx_q + 1'b1;
            end
         end else begin
            err_d = 1'b1;
            asm_d = '0;
            // A tag of 0 is taken as the start of a fresh word.
            if (sel_in == '0) begin
               asm_d[0] = bit_in;
               idx_d    = SEL_W'(1);
            end else begin
               idx_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         asm_q <= '0;
         out_q <= '0;
         ov_q  <= 1'b0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         idx_q <= idx_d;
         asm_q <= asm_d;
         out_q <= out_d;
         ov_q  <= ov_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_data  = out_q;
   assign out_valid = ov_q;
   assign seq_err   = err_q;
   assign busy      = (idx_q != '0);
   assign word_cnt  = cnt_q;

endmodule
